digimax_mixer: RTL and testbench
================================

Name: digimax_mixer

Overview:
- Audio back-end stage directly downstream of the DigiMax register block.
- Consumes the four 8-bit unsigned DAC latches (dac_0..dac_3) and, on each sample tick, snapshots and mixes them into a stereo pair: ch0+ch2 left, ch1+ch3 right.
- Each side is smoothed by a first-order IIR low-pass and scaled by a click-free fade gain.
- Delivers signed 16-bit samples with a one-cycle valid strobe to the core's audio mixer.

Parameters:
- FILT_SHIFT, 2, IIR coefficient as a right shift; y += (x - y) >>> FILT_SHIFT. Legal range 0..8; 0 = bypass (y = x).
- GAIN_MAX, 16, full-scale fade gain; output = (y * gain) >>> 4. Must equal 16.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ce_sample  in  1  sample-rate tick, one clk wide
- enable  in  1  1 = fade in / hold at full gain; 0 = fade out / hold muted
- dac_0  in  8  channel 0, unsigned, 0x80 = silence
- dac_1  in  8  channel 1
- dac_2  in  8  channel 2
- dac_3  in  8  channel 3
- out_l  out  16  left sample, signed
- out_r  out  16  right sample, signed
- sample_valid  out  1  one-cycle strobe: out_l/out_r updated
- active  out  1  gain != 0
- overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset state: FSM = IDLE; snapshots, x, y, gain, out_l, out_r all 0; sample_valid = 0; overrun = 0; active = 0. Asserting reset mid-sequence aborts the sequence; no valid strobe is produced.
- FSM states: IDLE -> CAPT -> FILT -> OUT -> IDLE, one clk per state.
- Edge E (IDLE, ce_sample = 1): register all four dac inputs simultaneously; go to CAPT. In IDLE with no tick, remain in IDLE.
- Edge E+1 (CAPT):
  - Convert each channel: s = dac - 128, 9-bit signed, range -128..127.
  - xl = (s0 + s2) << 6; xr = (s1 + s3) << 6. Range -16384..16256; never saturates.
- Edge E+2 (FILT):
  - Per side: d = x - y (17-bit signed); y <= y + (d >>> FILT_SHIFT). Arithmetic shift, truncation toward -inf.
  - Gain update: enable = 1 and gain < GAIN_MAX -> gain + 1; enable = 0 and gain > 0 -> gain - 1; otherwise hold.
- Edge E+3 (OUT):
  - out_l <= (yl * gain) >>> 4; out_r likewise. Uses the gain updated at E+2; product is 21-bit, keep the low 16 bits after the shift (always in range).
  - sample_valid <= 1 for exactly one cycle. out_l/out_r hold until the next OUT.
  - Latency: tick edge to valid = 3 clk. Minimum tick spacing = 4 clk.
- Overrun: a tick sampled in CAPT, FILT or OUT is ignored and sets overrun. overrun is cleared only by reset. The sample in flight completes normally.
- Gain movement: gain changes only once per processed sample. A full fade takes 16 samples. Toggling enable mid-fade reverses direction from the current gain.
- active = (gain != 0), registered with gain.
- Steady-state accuracy: all dacs at 0x80 with steady state reached gives exactly 0 on both outputs.

Test Plan:
- Reset with all dacs = 0x80, enable = 1, ticks every 8 clk: sample_valid exactly 3 clk after each tick. out_l = out_r = 0 throughout. active rises after the first sample.
- FILT_SHIFT = 0, enable = 1, dac0 = dac2 = 0xFF, dac1 = dac3 = 0x00:
  - Sample 1 (gain 1): out_l = 1016, out_r = -1024.
  - From sample 16 onward: out_l = 16256, out_r = -16384.
- FILT_SHIFT = 2, gain pre-ramped to 16 on silence, then dac0 = dac2 = 0xFF, others 0x80: out_l = 4064, 7112, then 9398; out_r stays 0.
- Fade-out: after full gain, drop enable. gain reaches 0 after 16 samples, active deasserts, and outputs are 0 from sample 16.
- Overrun: ticks 2 clk apart. Second tick ignored; overrun = 1 and stays set; exactly one sample_valid is produced.
- Reset pulse at E+2: all outputs return to 0 immediately (async). No sample_valid; the next tick after release processes normally with gain starting from 0.

Source files
------------

// File: rtl/digimax_mixer.sv
// DigiMax back-end: snapshots four 8-bit DACs per tick, mixes to stereo, IIR low-pass, fade gain.
// Latency 3 clk tick-to-valid; no backpressure, a tick while busy is dropped and flagged in overrun.
module digimax_mixer #(
  parameter int FILT_SHIFT = 2,
  parameter int GAIN_MAX   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_sample,
  input  logic        enable,
  input  logic [7:0]  dac_0,
  input  logic [7:0]  dac_1,
  input  logic [7:0]  dac_2,
  input  logic [7:0]  dac_3,
  output logic [15:0] out_l,
  output logic [15:0] out_r,
  output logic        sample_valid,
  output logic        active,
  output logic        overrun
);

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_FILT, S_OUT} state_t;

  state_t              r_state;
  logic [7:0]          r_dac0, r_dac1, r_dac2, r_dac3;
  logic signed [16:0]  r_xl, r_xr, r_yl, r_yr;
  logic [4:0]          r_gain;
  logic [15:0]         r_out_l, r_out_r;
  logic                r_valid, r_active, r_overrun;

  logic signed [8:0]   w_s0, w_s1, w_s2, w_s3;
  logic signed [9:0]   w_sum_l, w_sum_r;
  logic signed [16:0]  w_xl, w_xr, w_dl, w_dr, w_yl_nxt, w_yr_nxt;
  logic [4:0]          w_gain_nxt;
  logic signed [22:0]  w_pl, w_pr;

  // Offset-binary to two's complement: 0x80 maps to 0.
  assign w_s0 = $signed({1'b0, r_dac0} - 9'd128);
  assign w_s1 = $signed({1'b0, r_dac1} - 9'd128);
  assign w_s2 = $signed({1'b0, r_dac2} - 9'd128);
  assign w_s3 = $signed({1'b0, r_dac3} - 9'd128);

  assign w_sum_l = {w_s0[8], w_s0} + {w_s2[8], w_s2};
  assign w_sum_r = {w_s1[8], w_s1} + {w_s3[8], w_s3};
  assign w_xl    = {w_sum_l[9], w_sum_l, 6'b0};
  assign w_xr    = {w_sum_r[9], w_sum_r, 6'b0};

  assign w_dl     = r_xl - r_yl;
  assign w_dr     = r_xr - r_yr;
  assign w_yl_nxt = r_yl + (w_dl >>> FILT_SHIFT);
  assign w_yr_nxt = r_yr + (w_dr >>> FILT_SHIFT);

  always_comb begin
    w_gain_nxt = r_gain;
    if (enable && (r_gain < 5'(GAIN_MAX)))
      w_gain_nxt = r_gain + 5'd1;
    else if (!enable && (r_gain != 5'd0))
      w_gain_nxt = r_gain - 5'd1;
  end

  // Gain is at most 16, so the scaled product never exceeds the 16-bit range.
  assign w_pl = $signed({{6{r_yl[16]}}, r_yl}) * $signed({18'b0, r_gain});
  assign w_pr = $signed({{6{r_yr[16]}}, r_yr}) * $signed({18'b0, r_gain});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_dac0    <= '0;
      r_dac1    <= '0;
      r_dac2    <= '0;
      r_dac3    <= '0;
      r_xl      <= '0;
      r_xr      <= '0;
      r_yl      <= '0;
      r_yr      <= '0;
      r_gain    <= '0;
      r_out_l   <= '0;
      r_out_r   <= '0;
      r_valid   <= 1'b0;
      r_active  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (ce_sample && (r_state != S_IDLE))
        r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (ce_sample) begin
            r_dac0  <= dac_0;
            r_dac1  <= dac_1;
            r_dac2  <= dac_2;
            r_dac3  <= dac_3;
            r_state <= S_CAPT;
          end
        end
        S_CAPT: begin
          r_xl    <= w_xl;
          r_xr    <= w_xr;
          r_state <= S_FILT;
        end
        S_FILT: begin
          r_yl     <= w_yl_nxt;
          r_yr     <= w_yr_nxt;
          r_gain   <= w_gain_nxt;
          r_active <= (w_gain_nxt != 5'd0);
          r_state  <= S_OUT;
        end
        S_OUT: begin
          r_out_l <= 16'(w_pl >>> 4);
          r_out_r <= 16'(w_pr >>> 4);
          r_valid <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_l        = r_out_l;
  assign out_r        = r_out_r;
  assign sample_valid = r_valid;
  assign active       = r_active;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_digimax_mixer.sv
// Bench for digimax_mixer: two instances (FILT_SHIFT 0 and 2) share stimulus; a reference
// model pushes expected samples to a queue that the output monitor pops on sample_valid.
module tb_digimax_mixer;

  logic        clk = 1'b0;
  logic        reset_n, ce_sample, enable;
  logic [7:0]  dac_0, dac_1, dac_2, dac_3;
  logic [15:0] out_l0, out_r0, out_l2, out_r2;
  logic        sv0, sv2, act0, act2, ovr0, ovr2;

  always #5 clk = ~clk;

  digimax_mixer #(.FILT_SHIFT(0), .GAIN_MAX(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .ce_sample(ce_sample), .enable(enable),
    .dac_0(dac_0), .dac_1(dac_1), .dac_2(dac_2), .dac_3(dac_3),
    .out_l(out_l0), .out_r(out_r0), .sample_valid(sv0), .active(act0), .overrun(ovr0)
  );

  digimax_mixer #(.FILT_SHIFT(2), .GAIN_MAX(16)) dut2 (
    .clk(clk), .reset_n(reset_n), .ce_sample(ce_sample), .enable(enable),
    .dac_0(dac_0), .dac_1(dac_1), .dac_2(dac_2), .dac_3(dac_3),
    .out_l(out_l2), .out_r(out_r2), .sample_valid(sv2), .active(act2), .overrun(ovr2)
  );

  typedef struct {
    int l0;
    int r0;
    int l2;
    int r2;
  } exp_t;

  exp_t exp_q[$];
  int tests_run = 0;
  int failed    = 0;
  int n_valid   = 0;
  int cyc       = 0;
  int tick_cyc  = 0;
  int m_gain, m_yl0, m_yr0, m_yl2, m_yr2;
  int last_l0, last_r0, last_l2, last_r2;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_reset();
    m_gain = 0;
    m_yl0 = 0; m_yr0 = 0; m_yl2 = 0; m_yr2 = 0;
    exp_q.delete();
  endfunction

  function automatic void model_push();
    int xl, xr;
    exp_t e;
    xl = ((int'(dac_0) - 128) + (int'(dac_2) - 128)) * 64;
    xr = ((int'(dac_1) - 128) + (int'(dac_3) - 128)) * 64;
    if (enable && m_gain < 16) m_gain++;
    else if (!enable && m_gain > 0) m_gain--;
    m_yl0 = xl;
    m_yr0 = xr;
    m_yl2 = m_yl2 + ((xl - m_yl2) >>> 2);
    m_yr2 = m_yr2 + ((xr - m_yr2) >>> 2);
    e.l0 = (m_yl0 * m_gain) >>> 4;
    e.r0 = (m_yr0 * m_gain) >>> 4;
    e.l2 = (m_yl2 * m_gain) >>> 4;
    e.r2 = (m_yr2 * m_gain) >>> 4;
    exp_q.push_back(e);
  endfunction

  // Output monitor: pops the scoreboard on every valid strobe.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && (sv0 || sv2)) begin
      n_valid++;
      tests_run++;
      if (cyc - tick_cyc !== 3) begin
        failed++;
        $display("FAIL latency got %0d clk want 3", cyc - tick_cyc);
      end
      tests_run++;
      if (sv0 !== sv2) begin
        failed++;
        $display("FAIL valid_align sv0=%0b sv2=%0b", sv0, sv2);
      end
      if (exp_q.size() == 0) begin
        tests_run++;
        failed++;
        $display("FAIL unexpected_valid got strobe want none");
      end else begin
        e = exp_q.pop_front();
        last_l0 = int'($signed(out_l0));
        last_r0 = int'($signed(out_r0));
        last_l2 = int'($signed(out_l2));
        last_r2 = int'($signed(out_r2));
        tests_run++;
        if (last_l0 !== e.l0) begin failed++; $display("FAIL sb_out_l0 got %0d want %0d", last_l0, e.l0); end
        tests_run++;
        if (last_r0 !== e.r0) begin failed++; $display("FAIL sb_out_r0 got %0d want %0d", last_r0, e.r0); end
        tests_run++;
        if (last_l2 !== e.l2) begin failed++; $display("FAIL sb_out_l2 got %0d want %0d", last_l2, e.l2); end
        tests_run++;
        if (last_r2 !== e.r2) begin failed++; $display("FAIL sb_out_r2 got %0d want %0d", last_r2, e.r2); end
      end
    end
  end

  task automatic apply_reset();
    reset_n   = 1'b0;
    ce_sample = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic set_dacs(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    dac_0 = a; dac_1 = b; dac_2 = c; dac_3 = d;
  endtask

  task automatic do_tick();
    model_push();
    @(negedge clk);
    ce_sample = 1'b1;
    tick_cyc  = cyc + 1;
    @(negedge clk);
    ce_sample = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    set_dacs(8'h80, 8'h80, 8'h80, 8'h80);
    enable    = 1'b1;
    ce_sample = 1'b0;
    reset_n   = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_l0 !== 16'd0 || out_r0 !== 16'd0) begin
      failed++; $display("FAIL reset_out0 got %0d/%0d want 0/0", $signed(out_l0), $signed(out_r0));
    end
    tests_run++;
    if (out_l2 !== 16'd0 || out_r2 !== 16'd0) begin
      failed++; $display("FAIL reset_out2 got %0d/%0d want 0/0", $signed(out_l2), $signed(out_r2));
    end
    tests_run++;
    if ({sv0, act0, ovr0, sv2, act2, ovr2} !== 6'b0) begin
      failed++; $display("FAIL reset_flags got %b want 000000", {sv0, act0, ovr0, sv2, act2, ovr2});
    end
    apply_reset();
  endtask

  task automatic test_silence();
    int nv;
    apply_reset();
    set_dacs(8'h80, 8'h80, 8'h80, 8'h80);
    enable = 1'b1;
    nv = n_valid;
    tests_run++;
    if (act0 !== 1'b0) begin failed++; $display("FAIL silence_active_pre got %b want 0", act0); end
    for (int i = 0; i < 3; i++) begin
      do_tick();
      tests_run++;
      if (act0 !== 1'b1 || act2 !== 1'b1) begin
        failed++; $display("FAIL silence_active got %b%b want 11", act0, act2);
      end
      tests_run++;
      if (last_l0 !== 0 || last_r0 !== 0 || last_l2 !== 0 || last_r2 !== 0) begin
        failed++; $display("FAIL silence_out got %0d %0d %0d %0d want 0", last_l0, last_r0, last_l2, last_r2);
      end
    end
    tests_run++;
    if (n_valid !== nv + 3) begin failed++; $display("FAIL silence_count got %0d want 3", n_valid - nv); end
  endtask

  task automatic test_ramp();
    apply_reset();
    set_dacs(8'hFF, 8'h00, 8'hFF, 8'h00);
    enable = 1'b1;
    do_tick();
    tests_run++;
    if (last_l0 !== 1016 || last_r0 !== -1024) begin
      failed++; $display("FAIL ramp_first got %0d/%0d want 1016/-1024", last_l0, last_r0);
    end
    for (int i = 2; i <= 18; i++) begin
      do_tick();
      if (i >= 16) begin
        tests_run++;
        if (last_l0 !== 16256 || last_r0 !== -16384) begin
          failed++; $display("FAIL ramp_full_%0d got %0d/%0d want 16256/-16384", i, last_l0, last_r0);
        end
      end
    end
  endtask

  task automatic test_filter();
    int want[3];
    want[0] = 4064; want[1] = 7112; want[2] = 9398;
    apply_reset();
    set_dacs(8'h80, 8'h80, 8'h80, 8'h80);
    enable = 1'b1;
    repeat (16) do_tick();
    set_dacs(8'hFF, 8'h80, 8'hFF, 8'h80);
    for (int i = 0; i < 3; i++) begin
      do_tick();
      tests_run++;
      if (last_l2 !== want[i] || last_r2 !== 0) begin
        failed++; $display("FAIL filter_step%0d got %0d/%0d want %0d/0", i, last_l2, last_r2, want[i]);
      end
    end
  endtask

  task automatic test_fade();
    int nv;
    nv = n_valid;
    enable = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      do_tick();
      if (i == 15) begin
        tests_run++;
        if (act0 !== 1'b1) begin failed++; $display("FAIL fade_active15 got %b want 1", act0); end
      end
    end
    tests_run++;
    if (act0 !== 1'b0 || act2 !== 1'b0) begin
      failed++; $display("FAIL fade_active got %b%b want 00", act0, act2);
    end
    tests_run++;
    if (last_l0 !== 0 || last_r0 !== 0 || last_l2 !== 0 || last_r2 !== 0) begin
      failed++; $display("FAIL fade_out got %0d %0d %0d %0d want 0", last_l0, last_r0, last_l2, last_r2);
    end
    tests_run++;
    if (n_valid !== nv + 16) begin failed++; $display("FAIL fade_count got %0d want 16", n_valid - nv); end
  endtask

  task automatic test_overrun();
    int nv;
    apply_reset();
    set_dacs(8'hFF, 8'h00, 8'hFF, 8'h00);
    enable = 1'b1;
    nv = n_valid;
    model_push();
    @(negedge clk);
    ce_sample = 1'b1;
    tick_cyc  = cyc + 1;
    @(negedge clk);
    ce_sample = 1'b0;
    @(negedge clk);
    ce_sample = 1'b1;
    @(negedge clk);
    ce_sample = 1'b0;
    repeat (6) @(negedge clk);
    tests_run++;
    if (n_valid !== nv + 1) begin failed++; $display("FAIL overrun_count got %0d want 1", n_valid - nv); end
    tests_run++;
    if (ovr0 !== 1'b1 || ovr2 !== 1'b1) begin
      failed++; $display("FAIL overrun_flag got %b%b want 11", ovr0, ovr2);
    end
    do_tick();
    tests_run++;
    if (ovr0 !== 1'b1) begin failed++; $display("FAIL overrun_sticky got %b want 1", ovr0); end
    tests_run++;
    if (n_valid !== nv + 2) begin failed++; $display("FAIL overrun_next got %0d want 2", n_valid - nv); end
  endtask

  task automatic test_reset_mid();
    int nv;
    set_dacs(8'hFF, 8'h00, 8'hFF, 8'h00);
    enable = 1'b1;
    do_tick();
    do_tick();
    nv = n_valid;
    @(negedge clk);
    ce_sample = 1'b1;
    @(negedge clk);
    ce_sample = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (out_l0 !== 16'd0 || out_r0 !== 16'd0 || out_l2 !== 16'd0) begin
      failed++; $display("FAIL midreset_out got %0d/%0d/%0d want 0", $signed(out_l0), $signed(out_r0), $signed(out_l2));
    end
    tests_run++;
    if ({act0, ovr0, sv0} !== 3'b000) begin
      failed++; $display("FAIL midreset_flags got %b want 000", {act0, ovr0, sv0});
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (6) @(negedge clk);
    tests_run++;
    if (n_valid !== nv) begin failed++; $display("FAIL midreset_novalid got %0d want 0", n_valid - nv); end
    do_tick();
    tests_run++;
    if (n_valid !== nv + 1) begin failed++; $display("FAIL midreset_resume got %0d want 1", n_valid - nv); end
    tests_run++;
    if (last_l0 !== 1016 || last_r0 !== -1024) begin
      failed++; $display("FAIL midreset_gain1 got %0d/%0d want 1016/-1024", last_l0, last_r0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    ce_sample = 1'b0;
    enable    = 1'b0;
    set_dacs(8'h80, 8'h80, 8'h80, 8'h80);
    model_reset();
    test_reset();
    test_silence();
    test_ramp();
    test_filter();
    test_fade();
    test_overrun();
    test_reset_mid();
    tests_run++;
    if (exp_q.size() != 0) begin
      failed++; $display("FAIL leftover_expected got %0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
